// File: rtl/prog_sequencer_if.sv
// Control/status bundle between the program sequencer and its driver
// (instruction fetch address, decoder inputs, run handshake and LUT writes).
interface prog_sequencer_if #(
    parameter int unsigned D  = 10,
    parameter int unsigned LW = 3,
    parameter int unsigned CW = 16
) ();
    logic          req;
    logic          stall;
    logic          branch;
    logic [LW-1:0] idx;
    logic          halt;
    logic          lut_wr_en;
    logic [LW-1:0] lut_wr_idx;
    logic [D-1:0]  lut_wr_dat;
    logic [D-1:0]  prog_ctr;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycle_cnt;

    modport master (
        output req, stall, branch, idx, halt, lut_wr_en, lut_wr_idx, lut_wr_dat,
        input  prog_ctr, busy, done, timeout, cycle_cnt
    );

    modport slave (
        input  req, stall, branch, idx, halt, lut_wr_en, lut_wr_idx, lut_wr_dat,
        output prog_ctr, busy, done, timeout, cycle_cnt
    );
endinterface

// File: rtl/prog_sequencer.sv
// Program sequencer: owns the PC, a programmable branch-offset LUT and the req/done
// run control, with stall, halt, a run-cycle counter and a watchdog.
module prog_sequencer #(
    parameter int unsigned D        = 10,
    parameter int unsigned LW       = 3,
    parameter int unsigned START_PC = 0,
    parameter int unsigned HALT_PC  = 128,
    parameter int unsigned CW       = 16,
    parameter int unsigned MAX_CYC  = (1 << CW) - 1
) (
    input  logic            clk,
    input  logic            reset,
    prog_sequencer_if.slave bus
);
    localparam int unsigned Depth = 1 << LW;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q;
    logic [D-1:0]  pc_q;
    logic [CW-1:0] cnt_q;
    logic          timeout_q;
    logic [D-1:0]  lut_q [Depth];

    logic [D-1:0]  offset;
    logic          halt_exit;
    logic          wd_exit;

    // Stall masks the halt instruction but never the HALT_PC arrival check.
    assign offset    = lut_q[bus.idx];
    assign halt_exit = (bus.halt && !bus.stall) || (pc_q == D'(HALT_PC));
    assign wd_exit   = (cnt_q == CW'(MAX_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            pc_q      <= D'(START_PC);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req) begin
                        state_q   <= StRun;
                        pc_q      <= D'(START_PC);
                        cnt_q     <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                StRun: begin
                    // The terminating halt edge is not counted, so a run from START_PC
                    // to HALT_PC reports exactly the number of PC steps taken.
                    if (halt_exit) begin
                        state_q   <= StDone;
                        timeout_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (wd_exit) begin
                            state_q   <= StDone;
                            timeout_q <= 1'b1;
                        end else if (!bus.stall) begin
                            pc_q <= bus.branch ? pc_q + offset : pc_q + D'(1);
                        end
                    end
                end
                StDone: begin
                    if (!bus.req) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Registered LUT: a write and a branch on the same entry see the old offset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) begin
                lut_q[i] <= D'(1);
            end
        end else if (bus.lut_wr_en) begin
            lut_q[bus.lut_wr_idx] <= bus.lut_wr_dat;
        end
    end

    assign bus.prog_ctr  = pc_q;
    assign bus.busy      = (state_q == StRun);
    assign bus.done      = (state_q == StDone);
    assign bus.timeout   = timeout_q;
    assign bus.cycle_cnt = cnt_q;
endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: a default instance plus a short-watchdog instance.
module tb_prog_sequencer;
    logic clk;
    logic reset;

    int n_total = 0;
    int n_pass  = 0;

    prog_sequencer_if #(.D(10), .LW(3), .CW(16)) bus ();
    prog_sequencer_if #(.D(10), .LW(3), .CW(16)) wbus ();

    prog_sequencer #(
        .D(10), .LW(3), .START_PC(0), .HALT_PC(128), .CW(16), .MAX_CYC(65535)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    prog_sequencer #(
        .D(10), .LW(3), .START_PC(0), .HALT_PC(128), .CW(16), .MAX_CYC(20)
    ) u_wd (
        .clk   (clk),
        .reset (reset),
        .bus   (wbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int bad;
        reset = 1'b0;
        {bus.req, bus.stall, bus.branch, bus.idx, bus.halt} = '0;
        {bus.lut_wr_en, bus.lut_wr_idx, bus.lut_wr_dat} = '0;
        {wbus.req, wbus.stall, wbus.branch, wbus.idx, wbus.halt} = '0;
        {wbus.lut_wr_en, wbus.lut_wr_idx, wbus.lut_wr_dat} = '0;
        tick(); tick();
        check_eq("rst_pc", 32'(bus.prog_ctr), 0);
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_done", 32'(bus.done), 0);
        check_eq("rst_timeout", 32'(bus.timeout), 0);
        check_eq("rst_cnt", 32'(bus.cycle_cnt), 0);
        reset = 1'b1;
        tick();

        // 1: plain run from 0 to HALT_PC
        bus.req = 1'b1; tick(); bus.req = 1'b0;
        bad = 0;
        for (int i = 0; i <= 128; i++) begin
            if (bus.prog_ctr !== 10'(i) || bus.busy !== 1'b1) bad++;
            if (i < 128) tick();
        end
        check_eq("t1_seq_errors", 32'(bad), 0);
        tick();
        check_eq("t1_done", 32'(bus.done), 1);
        check_eq("t1_busy", 32'(bus.busy), 0);
        check_eq("t1_pc", 32'(bus.prog_ctr), 128);
        check_eq("t1_cnt", 32'(bus.cycle_cnt), 128);
        check_eq("t1_timeout", 32'(bus.timeout), 0);
        tick();
        check_eq("t1_idle_done", 32'(bus.done), 0);
        check_eq("t1_idle_pc", 32'(bus.prog_ctr), 128);

        // 2: negative offsets and wrap
        bus.lut_wr_en = 1'b1; bus.lut_wr_idx = 3'd2; bus.lut_wr_dat = 10'h3FD; tick();
        bus.lut_wr_idx = 3'd1; bus.lut_wr_dat = 10'h3FF; tick();
        bus.lut_wr_en = 1'b0;
        bus.req = 1'b1; tick(); bus.req = 1'b0;
        check_eq("t2_start_pc", 32'(bus.prog_ctr), 0);
        bus.branch = 1'b1; bus.idx = 3'd1; tick();
        check_eq("t2_wrap_down", 32'(bus.prog_ctr), 1023);
        bus.branch = 1'b0; tick();
        check_eq("t2_wrap_up", 32'(bus.prog_ctr), 0);
        repeat (10) tick();
        check_eq("t2_pc10", 32'(bus.prog_ctr), 10);
        bus.branch = 1'b1; bus.idx = 3'd2; tick();
        check_eq("t2_branch_m3", 32'(bus.prog_ctr), 7);
        bus.branch = 1'b0; bus.halt = 1'b1; tick();
        check_eq("t2_halt_done", 32'(bus.done), 1);
        check_eq("t2_halt_pc", 32'(bus.prog_ctr), 7);
        bus.halt = 1'b0; tick();

        // 3: stall masks branch and halt
        bus.req = 1'b1; tick(); bus.req = 1'b0;
        repeat (5) tick();
        check_eq("t3_pc5", 32'(bus.prog_ctr), 5);
        check_eq("t3_cnt5", 32'(bus.cycle_cnt), 5);
        bus.stall = 1'b1; bus.branch = 1'b1; bus.idx = 3'd0; bus.halt = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.prog_ctr !== 10'd5 || bus.done !== 1'b0 || bus.busy !== 1'b1) bad++;
        end
        check_eq("t3_stall_errors", 32'(bad), 0);
        check_eq("t3_cnt9", 32'(bus.cycle_cnt), 9);
        bus.stall = 1'b0; bus.branch = 1'b0; tick();
        check_eq("t3_done", 32'(bus.done), 1);
        check_eq("t3_pc", 32'(bus.prog_ctr), 5);
        check_eq("t3_timeout", 32'(bus.timeout), 0);
        bus.halt = 1'b0; tick();

        // 5: same-cycle LUT write uses old offset
        bus.req = 1'b1; tick(); bus.req = 1'b0;
        bus.branch = 1'b1; bus.idx = 3'd3;
        bus.lut_wr_en = 1'b1; bus.lut_wr_idx = 3'd3; bus.lut_wr_dat = 10'd5; tick();
        check_eq("t5_old_off", 32'(bus.prog_ctr), 1);
        bus.lut_wr_en = 1'b0; tick();
        check_eq("t5_new_off", 32'(bus.prog_ctr), 6);
        bus.branch = 1'b0; bus.halt = 1'b1; tick();
        bus.halt = 1'b0; tick();

        // 4: watchdog on the MAX_CYC=20 instance
        wbus.lut_wr_en = 1'b1; wbus.lut_wr_idx = 3'd0; wbus.lut_wr_dat = 10'd0; tick();
        wbus.lut_wr_en = 1'b0;
        wbus.req = 1'b1; tick(); wbus.req = 1'b0;
        wbus.branch = 1'b1; wbus.idx = 3'd0;
        repeat (19) tick();
        check_eq("t4_busy19", 32'(wbus.busy), 1);
        check_eq("t4_cnt19", 32'(wbus.cycle_cnt), 19);
        check_eq("t4_pc_spin", 32'(wbus.prog_ctr), 0);
        tick();
        check_eq("t4_wd_done", 32'(wbus.done), 1);
        check_eq("t4_wd_timeout", 32'(wbus.timeout), 1);
        check_eq("t4_wd_cnt", 32'(wbus.cycle_cnt), 20);
        tick();
        check_eq("t4_idle_timeout_hold", 32'(wbus.timeout), 1);
        wbus.req = 1'b1; tick(); wbus.req = 1'b0;
        check_eq("t4_restart_timeout", 32'(wbus.timeout), 0);
        check_eq("t4_restart_cnt", 32'(wbus.cycle_cnt), 0);
        repeat (19) tick();
        wbus.halt = 1'b1; tick();
        check_eq("t4_halt_done", 32'(wbus.done), 1);
        check_eq("t4_halt_timeout", 32'(wbus.timeout), 0);
        wbus.halt = 1'b0; wbus.branch = 1'b0; tick();

        // 6: async reset mid-run, then no auto-restart with req held
        bus.req = 1'b1; tick(); bus.req = 1'b0;
        repeat (40) tick();
        check_eq("t6_pc40", 32'(bus.prog_ctr), 40);
        reset = 1'b0;
        #1;
        check_eq("t6_rst_busy", 32'(bus.busy), 0);
        check_eq("t6_rst_pc", 32'(bus.prog_ctr), 0);
        check_eq("t6_rst_cnt", 32'(bus.cycle_cnt), 0);
        tick();
        reset = 1'b1;
        bus.req = 1'b1; tick();
        check_eq("t6_run_busy", 32'(bus.busy), 1);
        bus.branch = 1'b1; bus.idx = 3'd2; tick();
        check_eq("t6_lut_reset", 32'(bus.prog_ctr), 1);
        bus.branch = 1'b0; bus.halt = 1'b1; tick();
        check_eq("t6_done", 32'(bus.done), 1);
        bus.halt = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.prog_ctr !== 10'd1) bad++;
        end
        check_eq("t6_no_restart_errors", 32'(bad), 0);
        bus.req = 1'b0; tick();
        check_eq("t6_idle_done", 32'(bus.done), 0);
        check_eq("t6_idle_busy", 32'(bus.busy), 0);
        bus.req = 1'b1; tick(); bus.req = 1'b0;
        check_eq("t6_restart_busy", 32'(bus.busy), 1);
        check_eq("t6_restart_pc", 32'(bus.prog_ctr), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
